// File: rtl/dbg_rom_loader.sv
// Streams a byte image into the debug ROM segment, bracketed by holding the
// system in reset before the load and releasing it afterwards.
package mcs4;
    typedef logic [7:0] byte_t;
endpackage

package dbg;
    typedef logic [1:0] seg_t;
    typedef logic [7:0] seg_addr_t;
    typedef logic [9:0] addr_t;
    localparam seg_t      CTL = 2'd0;
    localparam seg_t      ROM = 2'd1;
    localparam seg_t      RAM = 2'd2;
    localparam seg_addr_t Ctl_sys_rst_addr = 8'h01;
endpackage

module dbg_rom_loader #(
    parameter logic [2:0] HOLD_RST = 3'b111,
    parameter logic [2:0] RUN_RST  = 3'b000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [$bits(dbg::seg_addr_t):0]    len,
    input  logic                               abort,
    input  logic                               in_valid,
    input  mcs4::byte_t                        in_data,
    output logic                               in_ready,
    output dbg::addr_t                         dbg_addr,
    output logic                               dbg_wen,
    output mcs4::byte_t                        dbg_wdata,
    output logic                               busy,
    output logic                               done,
    output logic                               aborted,
    output mcs4::byte_t                        checksum
);
    localparam int AW = $bits(dbg::seg_addr_t);
    localparam dbg::addr_t RST_REG_ADDR = {dbg::CTL, dbg::Ctl_sys_rst_addr};

    typedef enum logic [2:0] {IDLE, HOLD, LOAD, RELEASE, FIN} state_t;

    state_t      state_reg, state_next;
    logic [AW:0] len_reg, len_next;
    // One bit wider than the ROM index so len=2^AW terminates without wrapping.
    logic [AW:0] count_reg, count_next;
    mcs4::byte_t checksum_reg, checksum_next;
    dbg::addr_t  addr_reg, addr_next;
    logic        wen_reg, wen_next;
    mcs4::byte_t wdata_reg, wdata_next;
    logic        aborted_reg, aborted_next;
    logic        accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            count_reg    <= '0;
            checksum_reg <= '0;
            addr_reg     <= RST_REG_ADDR;
            wen_reg      <= 1'b0;
            wdata_reg    <= '0;
            aborted_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            count_reg    <= count_next;
            checksum_reg <= checksum_next;
            addr_reg     <= addr_next;
            wen_reg      <= wen_next;
            wdata_reg    <= wdata_next;
            aborted_reg  <= aborted_next;
        end
    end

    // Abort masks ready so the source never sees a handshake the loader drops.
    always_comb begin
        in_ready = (state_reg == LOAD) && (count_reg < len_reg) && !abort;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        count_next    = count_reg;
        checksum_next = checksum_reg;
        addr_next     = RST_REG_ADDR;
        wen_next      = 1'b0;
        wdata_next    = '0;
        aborted_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    len_next      = len;
                    count_next    = '0;
                    checksum_next = '0;
                    wen_next      = 1'b1;
                    wdata_next    = {5'd0, HOLD_RST};
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    aborted_next = 1'b1;
                    state_next   = IDLE;
                end else if (len_reg == '0) begin
                    state_next = RELEASE;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    aborted_next = 1'b1;
                    state_next   = IDLE;
                end else if (accept) begin
                    addr_next     = {dbg::ROM, count_reg[AW-1:0]};
                    wen_next      = 1'b1;
                    wdata_next    = in_data;
                    count_next    = count_reg + (AW+1)'(1);
                    checksum_next = checksum_reg + in_data;
                    if (count_next == len_reg) begin
                        state_next = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (abort) begin
                    aborted_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    wen_next   = 1'b1;
                    wdata_next = {5'd0, RUN_RST};
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The release write issued from RELEASE is on the bus during FIN, alongside done.
    assign dbg_addr  = addr_reg;
    assign dbg_wen   = wen_reg;
    assign dbg_wdata = wdata_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FIN);
    assign aborted   = aborted_reg;
    assign checksum  = checksum_reg;

endmodule

// File: tb/tb_dbg_rom_loader.sv
// Bench for dbg_rom_loader: directed vector table, randomized loads checked
// against a transaction-level model, and reset/abort corner sequences.
module tb_dbg_rom_loader;
    localparam logic [9:0] RST_ADDR = {dbg::CTL, dbg::Ctl_sys_rst_addr};

    logic        clk, rst, start, abort, in_valid, in_ready;
    logic [8:0]  len;
    mcs4::byte_t in_data, dbg_wdata, checksum;
    dbg::addr_t  dbg_addr;
    logic        dbg_wen, busy, done, aborted;

    dbg_rom_loader dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dbg_addr(dbg_addr), .dbg_wen(dbg_wen), .dbg_wdata(dbg_wdata),
        .busy(busy), .done(done), .aborted(aborted), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t log_q[$];
    int  done_cnt, abort_cnt;
    bit  mon_on = 0;

    // Bus monitor: collect every write, and insist an idle bus sits on the reset register.
    always @(negedge clk) begin
        wr_t w;
        if (mon_on) begin
            if (dbg_wen) begin
                w.addr = dbg_addr;
                w.data = dbg_wdata;
                w.cyc  = cyc;
                log_q.push_back(w);
            end else begin
                total++;
                if (dbg_addr !== RST_ADDR || dbg_wdata !== 8'h00) begin
                    bad++;
                    $display("FAIL idle_bus cyc=%0d got addr=%h data=%h want addr=%h data=00",
                             cyc, dbg_addr, dbg_wdata, RST_ADDR);
                end
            end
            if (done) done_cnt++;
            if (aborted) abort_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Drives one load and compares the observed write stream against the
    // expected transaction list: hold write, ROM bytes in order, release write.
    task automatic run_load(input string name, input int n, input int mode, input int ab,
                            input mcs4::byte_t bytes[$], input int exp_rom,
                            input int exp_done, input int exp_abort, input int exp_cks);
        int  sent = 0;
        int  k = 0;
        bit  fin = 0;
        bit  ab_issued = 0;
        wr_t exp_q[$];
        wr_t e;
        int  first_rom = -1;
        log_q.delete();
        done_cnt = 0;
        abort_cnt = 0;
        mon_on = 1;
        @(posedge clk); #1;
        start = 1; len = 9'(n);
        @(posedge clk); #1;
        start = 0;
        while (!fin && k < 2000) begin
            if (ab >= 0 && sent == ab && !ab_issued) begin
                abort = 1;
                ab_issued = 1;
            end
            if (mode == 0)      in_valid = (sent < n);
            else if (mode == 1) in_valid = (sent < n) && (k % 2 == 0);
            else                in_valid = (sent < n) && ($urandom_range(0, 1) == 1);
            in_data = (sent < n) ? bytes[sent] : 8'h00;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (done || aborted) fin = 1;
            @(posedge clk); #1;
            abort = 0;
            in_valid = 0;
            k++;
        end
        if (!fin) chk({name, "_timeout"}, 0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_on = 0;

        e.cyc = 0;
        e.addr = RST_ADDR; e.data = 8'h07; exp_q.push_back(e);
        for (int i = 0; i < exp_rom; i++) begin
            e.addr = {dbg::ROM, 8'(i)}; e.data = bytes[i]; exp_q.push_back(e);
        end
        if (exp_done != 0) begin
            e.addr = RST_ADDR; e.data = 8'h00; exp_q.push_back(e);
        end
        chk({name, "_nwrites"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("%s_wr%0d_addr", name, i), log_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s_wr%0d_data", name, i), log_q[i].data, exp_q[i].data);
        end
        if (mode == 0 && exp_rom > 1 && log_q.size() > exp_rom) begin
            for (int i = 2; i <= exp_rom; i++)
                chk($sformatf("%s_b2b%0d", name, i), log_q[i].cyc - log_q[i-1].cyc, 1);
        end
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].addr[9:8] == dbg::ROM && first_rom < 0) first_rom = i;
        if (exp_rom == 0) chk({name, "_no_rom"}, first_rom, -1);
        chk({name, "_done"}, done_cnt, exp_done);
        chk({name, "_aborted"}, abort_cnt, exp_abort);
        chk({name, "_checksum"}, checksum, exp_cks);
        chk({name, "_idle"}, busy, 0);
    endtask

    typedef struct {
        string       name;
        int          n;
        int          mode;
        int          ab;
        int          fill;
        logic [39:0] b;
        int          exp_rom;
        int          exp_done;
        int          exp_abort;
        int          exp_cks;
    } vec_t;

    vec_t vt[5];

    initial begin
        mcs4::byte_t bq[$];
        int n, mode, ab, acc, sum;
        int seen_hold;

        vt[0] = '{"b2b3",   3,   0, -1, 0, 40'h0000563412,   3, 1, 0, 8'h9C};
        vt[1] = '{"len0",   0,   0, -1, 0, 40'h0,            0, 1, 0, 8'h00};
        vt[2] = '{"toggle", 4,   1, -1, 0, 40'h00A3A2A1A0,   4, 1, 0, 8'h86};
        vt[3] = '{"abort2", 5,   0,  2, 0, 40'h5040302010,   2, 0, 1, 8'h30};
        vt[4] = '{"full",   256, 0, -1, 1, 40'h0,          256, 1, 0, 8'h00};

        rst = 1; start = 0; len = 0; abort = 0; in_valid = 1; in_data = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wen", dbg_wen, 0);
        chk("rst_addr", dbg_addr, RST_ADDR);
        chk("rst_wdata", dbg_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_checksum", checksum, 0);
        @(posedge clk); #1;
        rst = 0; in_valid = 0;

        // Abort while idle must not pulse aborted or leave IDLE.
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("idle_abort_pulse", aborted, 0);
        chk("idle_abort_busy", busy, 0);

        for (int r = 0; r < 5; r++) begin
            bq.delete();
            for (int i = 0; i < vt[r].n; i++)
                bq.push_back(vt[r].fill == 1 ? 8'h01 : vt[r].b[8*i +: 8]);
            run_load(vt[r].name, vt[r].n, vt[r].mode, vt[r].ab, bq,
                     vt[r].exp_rom, vt[r].exp_done, vt[r].exp_abort, vt[r].exp_cks);
            $display("vector %s len=%0d: writes=%0d checksum=%02h", vt[r].name, vt[r].n,
                     log_q.size(), checksum);
        end

        for (int r = 0; r < 10; r++) begin
            n    = $urandom_range(0, 20);
            mode = $urandom_range(0, 2);
            ab   = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            acc = (ab >= 0) ? ab : n;
            sum = 0;
            for (int i = 0; i < acc; i++) sum += bq[i];
            run_load($sformatf("rnd%0d", r), n, mode, ab, bq, acc,
                     (ab < 0) ? 1 : 0, (ab >= 0) ? 1 : 0, sum % 256);
            $display("random %0d len=%0d mode=%0d abort_at=%0d: writes=%0d checksum=%02h",
                     r, n, mode, ab, log_q.size(), checksum);
        end

        // start during LOAD is ignored; rst mid-load clears everything with no release.
        log_q.delete();
        done_cnt = 0;
        abort_cnt = 0;
        mon_on = 1;
        @(posedge clk); #1;
        start = 1; len = 9'd5;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1; in_data = 8'(8'h40 + k);
            start = (k == 3);
            @(posedge clk); #1;
        end
        start = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; in_valid = 1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_wen", dbg_wen, 0);
        chk("midrst_addr", dbg_addr, RST_ADDR);
        chk("midrst_wdata", dbg_wdata, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_checksum", checksum, 0);
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        mon_on = 0;
        seen_hold = 0;
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i].addr == RST_ADDR && log_q[i].data == 8'h07) seen_hold++;
        chk("midrst_one_hold", seen_hold, 1);
        chk("midrst_no_release", log_q[log_q.size()-1].addr[9:8], dbg::ROM);
        chk("midrst_done", done_cnt, 0);
        chk("midrst_aborted", abort_cnt, 0);
        $display("mid-load rst: writes=%0d", log_q.size());

        bq.delete();
        bq.push_back(8'h12); bq.push_back(8'h34); bq.push_back(8'h56);
        run_load("after_rst", 3, 0, -1, bq, 3, 1, 0, 8'h9C);
        $display("post-reset load: writes=%0d checksum=%02h", log_q.size(), checksum);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
